lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator that drives the single-port, word-addressed data memory (1-cycle registered read, read-before-write, no byte enables) on behalf of the CPU pipeline.
- Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW byte-address requests into word accesses.
- Performs lane extraction and sign/zero extension on loads, and read-modify-write for sub-word stores.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 12, word-index bits driven to memory (4096 words = 16 KB).
- XLEN, 32, data width; fixed at 32, parameter is for documentation only.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present; CPU holds the request stable until accepted
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse; CPU always accepts
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3, or (optionally) out of range
- mem_write_en  out  1  to data memory
- mem_addr  out  32  word index = {zeros, byte_addr[ADDR_W+1:2]}
- mem_write_data  out  32  to data memory
- mem_read_data  in  32  valid the cycle after the address is sampled

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
- mem_write_en is combinationally forced to 0 whenever rst=1.
- States: IDLE, LD_WAIT, RMW_WAIT, RMW_WR, RESP.
- Accept: handshake occurs at edge E0 when req_valid && req_ready.
- Memory port drive:
  - In IDLE, mem_addr and mem_write_data are combinational from the request.
  - In all other states they come from held registers (word index, byte lane, funct3, wdata).
- Error check at accept: any of the following → no memory write, go to RESP with resp_err=1, resp_rdata=0:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - funct3 ∈ {011, 110, 111}
  - a store with funct3 BU/HU
- SW: mem_write_en=1 in the accept cycle → RESP. resp_valid is high in the cycle after E0.
- Load: IDLE→LD_WAIT at E0.
  - In LD_WAIT, extract the lane from mem_read_data (lane = addr[1:0] for B, addr[1] for H).
  - Sign- or zero-extend per funct3.
  - Register the result at E1 → RESP. resp_valid is in the cycle after E1.
  - Throughput: one load per 3 cycles.
- SB/SH: IDLE→RMW_WAIT at E0, read only.
  - In RMW_WAIT, merge the low byte/half of the held wdata into mem_read_data at the lane.
  - Register the merged word at E1 → RMW_WR.
  - RMW_WR drives mem_write_en=1 with the held word index and merged data; write commits at E2 → RESP.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. Response outputs hold their value until the next response; only resp_valid pulses.
- req_valid while req_ready=0 is ignored and causes no side effect.
- Address bits above ADDR_W+1 are dropped, so addresses wrap modulo 16 KB.
- Reset in any state: abort to IDLE, no response.
  - A reset coinciding with RMW_WR suppresses the write, so memory is unchanged.

Optional Feature:
- LSU_RANGE_CHK_EN defined: at accept, req_addr ≥ 4·2^ADDR_W is an error (resp_err=1, no memory access, RESP path).
- Undefined: no check; high address bits are silently dropped (wrap).

Decomposition:
- lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state encoding
  - the error-condition function
- Sub-module lsu_align (combinational) provides:
  - extract(word, lane, funct3) → extended data
  - merge(word, lane, funct3, wdata) → store word
- lsu_ctrl keeps the FSM and held registers.

Test Plan:
- SW 0x10, 0xDEADBEEF → mem_write_en=1, mem_addr=4 at accept; resp_valid next cycle, err=0. Then LW 0x10 → resp_rdata=0xDEADBEEF, resp_valid 2 cycles after the accept cycle.
- SB 0x13, wdata 0x123456A5 over 0xDEADBEEF → one read then one write of 0xA5ADBEEF. LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- SH 0x10, 0x00008001 over 0xA5ADBEEF → word 0xA5AD8001. LH 0x10 → 0xFFFF8001; LHU 0x12 → 0x0000A5AD.
- LW 0x11, SH 0x13, and funct3=011 each → resp_err=1, resp_rdata=0, mem_write_en never asserted, resp_valid one cycle after accept.
- rst pulsed during RMW_WAIT of SB 0x10 and, separately, during RMW_WR → mem_write_en stays 0, word unchanged, no resp_valid, req_ready=1 the cycle after reset.
- LW 0x4000 after SW 0x0 of 0x11111111 → with LSU_RANGE_CHK_EN: resp_err=1; without it: resp_rdata=0x11111111 (wrap to word 0).

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding,
// and the access-legality check applied to every request at accept time.
// Purely declarative; no ports, no latency, no backpressure.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_RMW_WAIT,
        S_RMW_WR,
        S_RESP
    } state_t;

    // Misalignment, reserved funct3 codes, and stores using an unsigned-load code.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] ofs);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = ofs[0];
            F3_W:    err = (ofs != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | ofs[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the CPU request/response handshake and the data-memory port.
// slave: the load/store unit; master: the CPU pipeline plus data memory.
// req_valid/req_ready handshake; responses and memory writes are never stalled.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_write_en, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_write_en, mem_addr, mem_write_data
    );
endinterface

// File: rtl/lsu_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Purely combinational, zero latency; no handshake, no backpressure.
// Ports: word (memory word), lane (byte offset), funct3, wdata -> ld_data, st_word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = word;
        case (funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'h0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'h0, half_sel};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        st_word = word;
        case (funct3)
            F3_B: st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator on a single-port word memory (registered read, RMW for SB/SH).
// Latency after accept: SW/errors 1 cycle, loads 2, SB/SH 3; one request in flight.
// req_ready only in IDLE; resp_valid is a one-cycle pulse the CPU always takes.
// Ports: clk, rst (sync, active-high), bus (lsu_if.slave).
// Build option: LSU_RANGE_CHK_EN flags addresses beyond the 4*2^ADDR_W byte window.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int XLEN   = 32
) (
    input  logic   clk,
    input  logic   rst,
    lsu_if.slave   bus
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] hold_widx;
    logic [1:0]        hold_lane;
    logic [2:0]        hold_f3;
    logic [XLEN-1:0]   hold_wdata;   // store data, replaced by the merged word in RMW
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] widx;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   st_word;
    logic              accept;
    logic              req_err;

    assign accept = bus.req_valid && (state == S_IDLE);

`ifdef LSU_RANGE_CHK_EN
    assign req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
                   || (bus.req_addr[31:ADDR_W+2] != '0);
`else
    // High address bits are dropped, so accesses wrap around the memory.
    assign req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
`endif

    lsu_align u_align (
        .word    (bus.mem_read_data),
        .lane    (hold_lane),
        .funct3  (hold_f3),
        .wdata   (hold_wdata),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.mem_write_en   = 1'b0;
        widx               = hold_widx;
        bus.mem_write_data = hold_wdata;
        case (state)
            S_IDLE: begin
                // The memory sees the live request so SW and the RMW read start at accept.
                bus.req_ready      = 1'b1;
                widx               = bus.req_addr[ADDR_W+1:2];
                bus.mem_write_data = bus.req_wdata;
                if (accept) begin
                    if (req_err) begin
                        state_nxt = S_RESP;
                    end else if (!bus.req_we) begin
                        state_nxt = S_LD_WAIT;
                    end else if (bus.req_funct3 == F3_W) begin
                        bus.mem_write_en = 1'b1;
                        state_nxt        = S_RESP;
                    end else begin
                        state_nxt = S_RMW_WAIT;
                    end
                end
            end
            S_LD_WAIT:  state_nxt = S_RESP;
            S_RMW_WAIT: state_nxt = S_RMW_WR;
            S_RMW_WR: begin
                bus.mem_write_en = 1'b1;
                state_nxt        = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A reset landing on a write cycle must leave memory untouched.
        if (rst) bus.mem_write_en = 1'b0;
    end

    assign bus.mem_addr   = {{(XLEN-ADDR_W){1'b0}}, widx};
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_widx  <= '0;
            hold_lane  <= '0;
            hold_f3    <= '0;
            hold_wdata <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        hold_widx  <= widx;
                        hold_lane  <= bus.req_addr[1:0];
                        hold_f3    <= bus.req_funct3;
                        hold_wdata <= bus.req_wdata;
                        if (state_nxt == S_RESP) begin
                            rdata_q <= '0;
                            err_q   <= req_err;
                        end
                    end
                end
                S_LD_WAIT: begin
                    rdata_q <= ld_data;
                    err_q   <= 1'b0;
                end
                S_RMW_WAIT: hold_wdata <= st_word;
                S_RMW_WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus random traffic against a byte-array model.
// Acts as CPU and as the data memory (1-cycle registered read, read-before-write).
// Requests are issued one at a time; garbage requests are driven while the unit is busy.
module tb_lsu_ctrl;
    localparam int ADDR_W    = 12;
    localparam int MEM_BYTES = 4 << ADDR_W;

    logic clk;
    logic rst;
    lsu_if bus();

    lsu_ctrl #(.ADDR_W(ADDR_W), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: 32'h0};
    byte unsigned ref_mem [0:MEM_BYTES-1] = '{default: 8'h0};
    int          n_wr   = 0;
    int          n_resp = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          n_chk  = 0;
    int          n_pass = 0;

    always @(posedge clk) begin
        bus.mem_read_data <= mem[bus.mem_addr[ADDR_W-1:0]];
        if (bus.mem_write_en) begin
            mem[bus.mem_addr[ADDR_W-1:0]] <= bus.mem_write_data;
            n_wr++;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_write_data;
        end
        if (bus.resp_valid) n_resp++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        if ((addr % size_of(f3)) != 0) return 1'b1;
`ifdef LSU_RANGE_CHK_EN
        if (addr >= MEM_BYTES) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a);
        longint v;
        int     sz;
        sz = size_of(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_mem[a+i]) << (8*i);
        if (f3 < 3'd4 && sz < 4 && v >= (64'd1 << (8*sz-1))) v -= (64'd1 << (8*sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic model_store(input int a, input int sz, input logic [31:0] wd);
        for (int i = 0; i < sz; i++) ref_mem[a+i] = wd[8*i +: 8];
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int wrs, output logic rdy, output logic tail);
        int w0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        w0  = n_wr;
        rdy = bus.req_ready;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = i;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                bus.req_valid = 1'b0;
            end else begin
                bus.req_valid  = 1'b1;
                bus.req_we     = 1'($urandom_range(0, 1));
                bus.req_funct3 = 3'($urandom_range(0, 7));
                bus.req_addr   = $urandom;
                bus.req_wdata  = $urandom;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        tail = bus.resp_valid;
        wrs  = n_wr - w0;
    endtask

    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        logic        e_err, er, rdy, tail;
        logic [31:0] e_rd;
        int          e_lat, e_wrs, lat, wrs, a, sz;
        e_err = exp_err(we, f3, addr);
        sz    = size_of(f3);
        a     = int'(addr % MEM_BYTES);
        e_rd  = '0;
        if (e_err)    begin e_lat = 1; e_wrs = 0; end
        else if (we)  begin e_lat = (sz == 4) ? 1 : 3; e_wrs = 1; end
        else          begin e_lat = 2; e_wrs = 0; e_rd = exp_load(f3, a); end
        do_op(we, f3, addr, wd, rd, er, lat, wrs, rdy, tail);
        chk({tag, ".ready"}, 32'(rdy), 32'd1);
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".err"},   32'(er), 32'(e_err));
        chk({tag, ".lat"},   32'(lat), 32'(e_lat));
        chk({tag, ".writes"}, 32'(wrs), 32'(e_wrs));
        chk({tag, ".pulse"}, 32'(tail), 32'd0);
        if (!e_err && we) begin
            model_store(a, sz, wd);
            chk({tag, ".waddr"}, last_wr_addr, 32'(a / 4));
            chk({tag, ".wdata"}, last_wr_data, model_word(a & ~3));
        end
    endtask

    task automatic rst_during(input string tag, input int cyc);
        int w0, r0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h77;
        w0 = n_wr;
        r0 = n_resp;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (cyc == 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, ".writes"}, 32'(n_wr - w0), 32'd0);
        chk({tag, ".resps"},  32'(n_resp - r0), 32'd0);
        chk({tag, ".word"},   mem[4], model_word(32'h10));
    endtask

    initial begin
        logic [31:0] rd, addr, wd;
        logic [2:0]  f3;
        logic        we;
        int          sz;

        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst.wen", 32'(bus.mem_write_en), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        chk("rst.vld",   32'(bus.resp_valid), 32'd0);
        chk("rst.rdata", bus.resp_rdata, 32'd0);
        chk("rst.err",   32'(bus.resp_err), 32'd0);
        chk("rst.nowr",  32'(n_wr), 32'd0);

        run_op("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
        chk("sw.idx", last_wr_addr, 32'd4);
        run_op("lw",  1'b0, 3'b010, 32'h10, 32'h0, rd);
        chk("lw.val", rd, 32'hDEADBEEF);
        run_op("sb",  1'b1, 3'b000, 32'h13, 32'h123456A5, rd);
        chk("sb.word", last_wr_data, 32'hA5ADBEEF);
        run_op("lb",  1'b0, 3'b000, 32'h13, 32'h0, rd);
        chk("lb.val", rd, 32'hFFFFFFA5);
        run_op("lbu", 1'b0, 3'b100, 32'h13, 32'h0, rd);
        chk("lbu.val", rd, 32'h000000A5);
        run_op("sh",  1'b1, 3'b001, 32'h10, 32'h00008001, rd);
        chk("sh.word", last_wr_data, 32'hA5AD8001);
        run_op("lh",  1'b0, 3'b001, 32'h10, 32'h0, rd);
        chk("lh.val", rd, 32'hFFFF8001);
        run_op("lhu", 1'b0, 3'b101, 32'h12, 32'h0, rd);
        chk("lhu.val", rd, 32'h0000A5AD);
        run_op("e_lw11", 1'b0, 3'b010, 32'h11, 32'h0, rd);
        run_op("e_sh13", 1'b1, 3'b001, 32'h13, 32'h5555, rd);
        run_op("e_f011", 1'b0, 3'b011, 32'h10, 32'h0, rd);
        run_op("e_sbu",  1'b1, 3'b100, 32'h10, 32'h66, rd);

        rst_during("rst_rmw_wait", 1);
        rst_during("rst_rmw_wr",   2);

        run_op("sw0", 1'b1, 3'b010, 32'h0, 32'h11111111, rd);
        run_op("lw4k", 1'b0, 3'b010, 32'h4000, 32'h0, rd);
`ifdef LSU_RANGE_CHK_EN
        chk("wrap.rdata", rd, 32'h0);
`else
        chk("wrap.rdata", rd, 32'h11111111);
`endif

        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            sz   = size_of(f3);
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h4000 << $urandom_range(0, 17));
            wd = $urandom;
            run_op($sformatf("rnd%0d", n), we, f3, addr, wd, rd);
        end

        for (int i = 0; i < 16; i++)
            chk($sformatf("final.mem%0d", i), mem[i], model_word(4*i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
